// File: rtl/display_latch_bank.sv
// Multi-channel display latch: live bank written over a shared bus, shadow bank
// refreshed at frame wrap, scanned out one channel per SCAN_DIV clock slot.
module display_latch_bank #(
  parameter int WIDTH    = 12,
  parameter int CHANNELS = 4,
  parameter int CH_W     = 2,
  parameter int SCAN_DIV = 1000
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                ENA_N,
  input  logic [CH_W-1:0]     WR_SEL,
  input  logic [WIDTH-1:0]    INPUT,
  input  logic                FREEZE,
  input  logic                SCAN_EN,
  output logic [CH_W-1:0]     SCAN_IDX,
  output logic [CHANNELS-1:0] SCAN_SEL,
  output logic [WIDTH-1:0]    SCAN_DATA,
  output logic                FRAME,
  output logic                WR_ERR
);

  localparam int                  DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CH_W-1:0]     IDX_LAST = CH_W'(CHANNELS - 1);
  // One extra bit so the range check stays meaningful when CHANNELS == 2**CH_W.
  localparam logic [CH_W:0]       CH_LIMIT = (CH_W + 1)'(CHANNELS);
  localparam logic [CHANNELS-1:0] SEL_RST  = CHANNELS'(1);

  logic [WIDTH-1:0]    live   [CHANNELS];
  logic [WIDTH-1:0]    shadow [CHANNELS];
  logic [DIV_W-1:0]    div_cnt;
  logic [CH_W-1:0]     idx;
  logic [CH_W-1:0]     idx_next;
  logic [CHANNELS-1:0] sel;
  logic [CHANNELS-1:0] sel_next;
  logic                frame;
  logic                wr_err;
  logic                tick;
  logic                wrap;
  logic                sel_in_range;
  logic                wr_hit;
  logic                wr_bad;
  logic [WIDTH-1:0]    data_mux;

  always_comb begin
    tick         = SCAN_EN && (div_cnt == DIV_LAST);
    wrap         = tick && (idx == IDX_LAST);
    sel_in_range = ({1'b0, WR_SEL} < CH_LIMIT);
    wr_hit       = !ENA_N && sel_in_range;
    wr_bad       = !ENA_N && !sel_in_range;
    idx_next     = wrap ? '0 : idx + 1'b1;
  end

  // SCAN_SEL is registered from the decoded next index so the digit select never glitches.
  always_comb begin
    sel_next = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (idx_next == CH_W'(i)) sel_next[i] = 1'b1;
    end
  end

  always_comb begin
    data_mux = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (idx == CH_W'(i)) data_mux = shadow[i];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      div_cnt <= '0;
      idx     <= '0;
      sel     <= SEL_RST;
      frame   <= 1'b0;
    end else begin
      if (SCAN_EN) div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) begin
        idx <= idx_next;
        sel <= sel_next;
      end
      frame <= wrap;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_err <= 1'b0;
    end else if (wr_bad) begin
      wr_err <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < CHANNELS; i++) live[i] <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (wr_hit && (WR_SEL == CH_W'(i))) live[i] <= INPUT;
      end
    end
  end

  // Shadow takes pre-edge live values, so a write on the wrap edge shows one frame later.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < CHANNELS; i++) shadow[i] <= '0;
    end else if (wrap && !FREEZE) begin
      for (int i = 0; i < CHANNELS; i++) shadow[i] <= live[i];
    end
  end

  assign SCAN_IDX  = idx;
  assign SCAN_SEL  = sel;
  assign SCAN_DATA = data_mux;
  assign FRAME     = frame;
  assign WR_ERR    = wr_err;

endmodule

// File: tb/tb_display_latch_bank.sv
// Directed bench: 4-channel/div-4 instance for scan, freeze and wrap-edge writes;
// 3-channel/div-1 instance for out-of-range writes and single-cycle slots.
module tb_display_latch_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        ena_n, freeze, scan_en;
  logic [1:0]  wr_sel;
  logic [11:0] din;
  logic [1:0]  scan_idx;
  logic [3:0]  scan_sel;
  logic [11:0] scan_data;
  logic        frame, wr_err;

  logic        b_ena_n, b_freeze, b_scan_en;
  logic [1:0]  b_wr_sel;
  logic [11:0] b_din;
  logic [1:0]  b_scan_idx;
  logic [2:0]  b_scan_sel;
  logic [11:0] b_scan_data;
  logic        b_frame, b_wr_err;

  display_latch_bank #(.WIDTH(12), .CHANNELS(4), .CH_W(2), .SCAN_DIV(4)) dut (
    .CLK(clk), .RST(rst), .ENA_N(ena_n), .WR_SEL(wr_sel), .INPUT(din),
    .FREEZE(freeze), .SCAN_EN(scan_en), .SCAN_IDX(scan_idx), .SCAN_SEL(scan_sel),
    .SCAN_DATA(scan_data), .FRAME(frame), .WR_ERR(wr_err)
  );

  display_latch_bank #(.WIDTH(12), .CHANNELS(3), .CH_W(2), .SCAN_DIV(1)) dut3 (
    .CLK(clk), .RST(rst), .ENA_N(b_ena_n), .WR_SEL(b_wr_sel), .INPUT(b_din),
    .FREEZE(b_freeze), .SCAN_EN(b_scan_en), .SCAN_IDX(b_scan_idx), .SCAN_SEL(b_scan_sel),
    .SCAN_DATA(b_scan_data), .FRAME(b_frame), .WR_ERR(b_wr_err)
  );

  int          n_vec  = 0;
  int          n_miss = 0;
  int          cyc    = 0;
  logic [11:0] vals    [4] = '{12'h123, 12'h456, 12'h789, 12'hABC};
  logic [11:0] exp_sh  [4];
  logic [11:0] exp_nxt [4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Steps the 4-channel instance with scanning on; slot = 4 cycles, frame = 16.
  task automatic run_cyc(input int n);
    int e;
    for (int i = 0; i < n; i++) begin
      step(1);
      cyc++;
      if (cyc % 16 == 0) begin
        for (int j = 0; j < 4; j++) exp_sh[j] = exp_nxt[j];
      end
      e = (cyc % 16) / 4;
      check("scan_idx",  32'(scan_idx),  32'(e));
      check("scan_sel",  32'(scan_sel),  32'(1 << e));
      check("scan_data", 32'(scan_data), 32'(exp_sh[e]));
      check("frame",     32'(frame),     32'(cyc % 16 == 0));
    end
  endtask

  logic [1:0]  b_exp_idx  [6] = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0};
  logic [11:0] b_exp_data [6] = '{12'h000, 12'h000, 12'h111, 12'h222, 12'h333, 12'h111};
  logic        b_exp_frm  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    for (int j = 0; j < 4; j++) begin
      exp_sh[j]  = '0;
      exp_nxt[j] = '0;
    end
    // Reset held while writes and scanning are requested on both instances.
    rst = 1'b1; ena_n = 1'b0; wr_sel = 2'd0; din = 12'hFFF; freeze = 1'b0; scan_en = 1'b1;
    b_ena_n = 1'b0; b_wr_sel = 2'd3; b_din = 12'hFFF; b_freeze = 1'b0; b_scan_en = 1'b1;
    step(2);
    check("rst_idx",    32'(scan_idx),    32'd0);
    check("rst_sel",    32'(scan_sel),    32'h1);
    check("rst_data",   32'(scan_data),   32'h0);
    check("rst_frame",  32'(frame),       32'd0);
    check("rst_wr_err", 32'(wr_err),      32'd0);
    check("b_rst_idx",  32'(b_scan_idx),  32'd0);
    check("b_rst_sel",  32'(b_scan_sel),  32'h1);
    check("b_rst_err",  32'(b_wr_err),    32'd0);
    check("b_rst_frm",  32'(b_frame),     32'd0);

    // Two frames with no writes: second frame shows the copied live bank, all zero.
    rst = 1'b0; ena_n = 1'b1; b_ena_n = 1'b1; b_scan_en = 1'b0;
    run_cyc(32);

    scan_en = 1'b0;
    for (int ch = 0; ch < 4; ch++) begin
      ena_n = 1'b0; wr_sel = 2'(ch); din = vals[ch];
      step(1);
    end
    ena_n = 1'b1; scan_en = 1'b1;
    for (int j = 0; j < 4; j++) exp_nxt[j] = vals[j];
    run_cyc(32);

    // Frozen across three wraps, then released.
    freeze = 1'b1; ena_n = 1'b0; wr_sel = 2'd1; din = 12'hFFF;
    run_cyc(1);
    ena_n = 1'b1;
    run_cyc(47);
    freeze = 1'b0;
    exp_nxt[1] = 12'hFFF;
    run_cyc(32);

    // Write coinciding with the wrap-tick edge.
    run_cyc(15);
    ena_n = 1'b0; wr_sel = 2'd2; din = 12'h5A5;
    run_cyc(1);
    ena_n = 1'b1;
    exp_nxt[2] = 12'h5A5;
    run_cyc(32);

    // Pause two cycles into a slot.
    run_cyc(2);
    scan_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("pause_idx",   32'(scan_idx),  32'd0);
      check("pause_sel",   32'(scan_sel),  32'h1);
      check("pause_data",  32'(scan_data), 32'h123);
      check("pause_frame", 32'(frame),     32'd0);
    end
    scan_en = 1'b1;
    run_cyc(2);
    check("wr_err_clean", 32'(wr_err), 32'd0);
    scan_en = 1'b0;

    // Three-channel instance: out-of-range write, then one-cycle slots.
    b_ena_n = 1'b0; b_wr_sel = 2'd0; b_din = 12'h111; step(1);
    b_wr_sel = 2'd1; b_din = 12'h222; step(1);
    b_wr_sel = 2'd2; b_din = 12'h333; step(1);
    check("b_err_before", 32'(b_wr_err), 32'd0);
    b_wr_sel = 2'd3; b_din = 12'h777; step(1);
    check("b_err_set", 32'(b_wr_err), 32'd1);
    b_ena_n = 1'b1; step(1);
    check("b_err_sticky", 32'(b_wr_err), 32'd1);
    b_scan_en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step(1);
      check("b_idx",   32'(b_scan_idx),  32'(b_exp_idx[k]));
      check("b_sel",   32'(b_scan_sel),  32'(1 << b_exp_idx[k]));
      check("b_data",  32'(b_scan_data), 32'(b_exp_data[k]));
      check("b_frame", 32'(b_frame),     32'(b_exp_frm[k]));
    end
    check("b_err_hold", 32'(b_wr_err), 32'd1);

    rst = 1'b1; step(1);
    rst = 1'b0; b_scan_en = 1'b0;
    check("b_err_clr",   32'(b_wr_err),    32'd0);
    check("b_clr_idx",   32'(b_scan_idx),  32'd0);
    check("b_clr_sel",   32'(b_scan_sel),  32'h1);
    check("b_clr_data",  32'(b_scan_data), 32'h0);
    check("clr_idx",     32'(scan_idx),    32'd0);
    check("clr_data",    32'(scan_data),   32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
